// File: rtl/jk_seq_decoder.sv
// jk_seq_decoder: receive-side decoder for the JK sequence counter stream
// 0->3->5->4->7->2->0. Decodes each code to its sequence position,
// acquires and tracks lock, flags illegal codes and out-of-order steps,
// and keeps a saturating error count.
//
// Handshake: code_valid is a pure qualifier with no backpressure. code_in
// is consumed on every rising edge where code_valid=1. Cycles with
// code_valid=0 are ignored entirely: state, counters, prev and index hold,
// and all pulse outputs are 0 on the following cycle.
//
// Every output is registered and reflects the sample taken on the
// previous edge.
module jk_seq_decoder #(
  parameter int LOCK_N   = 2,
  parameter int UNLOCK_N = 2,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [2:0]       code_in,
  input  logic             code_valid,
  output logic [2:0]       index,
  output logic             index_valid,
  output logic             locked,
  output logic             err_pulse,
  output logic             wrap_pulse,
  output logic [ERR_W-1:0] err_count
);

  // Counters only ever need to reach their threshold value.
  localparam int GOOD_W = $clog2(LOCK_N + 1);
  localparam int BAD_W  = $clog2(UNLOCK_N + 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t            state;
  logic [2:0]        prev;
  logic              prev_ok;
  logic [GOOD_W-1:0] good_cnt;
  logic [BAD_W-1:0]  bad_cnt;

  // Successor of a code in the counter sequence. Illegal codes map to 0,
  // which never matters because a match also requires a legal prev.
  function automatic logic [2:0] next_code(input logic [2:0] c);
    logic [2:0] n;
    case (c)
      3'd0:    n = 3'd3;
      3'd3:    n = 3'd5;
      3'd5:    n = 3'd4;
      3'd4:    n = 3'd7;
      3'd7:    n = 3'd2;
      3'd2:    n = 3'd0;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

  // Sequence position of a legal code; illegal codes are never stored.
  function automatic logic [2:0] code_pos(input logic [2:0] c);
    logic [2:0] p;
    case (c)
      3'd0:    p = 3'd0;
      3'd3:    p = 3'd1;
      3'd5:    p = 3'd2;
      3'd4:    p = 3'd3;
      3'd7:    p = 3'd4;
      3'd2:    p = 3'd5;
      default: p = 3'd0;
    endcase
    return p;
  endfunction

  logic              legal;
  logic              match;
  logic [2:0]        pos;
  logic [GOOD_W-1:0] good_inc;
  logic [BAD_W-1:0]  bad_inc;
  logic              good_done;
  logic              bad_done;
  logic              err_sat;

  // Per-sample classification and next-count values.
  always_comb begin
    legal     = (code_in != 3'd1) && (code_in != 3'd6);
    match     = prev_ok && legal && (code_in == next_code(prev));
    pos       = code_pos(code_in);
    good_inc  = good_cnt + GOOD_W'(1);
    bad_inc   = bad_cnt + BAD_W'(1);
    good_done = (good_inc == GOOD_W'(LOCK_N));
    bad_done  = (bad_inc == BAD_W'(UNLOCK_N));
    err_sat   = &err_count;
  end

  // Lock FSM with registered outputs; clear wins over everything.
  always_ff @(posedge clk) begin
    if (clear) begin
      state       <= HUNT;
      prev        <= 3'd0;
      prev_ok     <= 1'b0;
      good_cnt    <= '0;
      bad_cnt     <= '0;
      index       <= 3'd0;
      index_valid <= 1'b0;
      locked      <= 1'b0;
      err_pulse   <= 1'b0;
      wrap_pulse  <= 1'b0;
      err_count   <= '0;
    end else begin
      // Pulses are single-cycle unless re-asserted by this sample.
      index_valid <= 1'b0;
      err_pulse   <= 1'b0;
      wrap_pulse  <= 1'b0;

      if (code_valid) begin
        // The previous-code register follows every valid sample, so a
        // legal mismatch re-anchors the comparison on the new code.
        prev_ok <= legal;
        if (legal) begin
          prev        <= code_in;
          index       <= pos;
          index_valid <= 1'b1;
        end

        case (state)
          HUNT: begin
            if (legal) begin
              state    <= ACQ;
              good_cnt <= '0;
            end
          end

          ACQ: begin
            if (!legal) begin
              state    <= HUNT;
              good_cnt <= '0;
            end else if (match) begin
              if (good_done) begin
                state    <= LOCKED;
                locked   <= 1'b1;
                bad_cnt  <= '0;
                good_cnt <= '0;
              end else begin
                good_cnt <= good_inc;
              end
            end else begin
              good_cnt <= '0;
            end
          end

          LOCKED: begin
            if (match) begin
              bad_cnt    <= '0;
              wrap_pulse <= (code_in == 3'd0);
            end else begin
              err_pulse <= 1'b1;
              if (!err_sat) begin
                err_count <= err_count + ERR_W'(1);
              end
              if (bad_done) begin
                // locked drops in the same cycle err_pulse reports this sample.
                locked   <= 1'b0;
                bad_cnt  <= '0;
                good_cnt <= '0;
                state    <= legal ? ACQ : HUNT;
              end else begin
                bad_cnt <= bad_inc;
              end
            end
          end

          default: begin
            state    <= HUNT;
            locked   <= 1'b0;
            good_cnt <= '0;
            bad_cnt  <= '0;
          end
        endcase
      end
    end
  end

endmodule
